// File: rtl/fifo_pkg.sv
// Shared constants for the parametrised FIFO: reset values and error bit layout.
// The optional sticky error flags are enabled with the FIFO_ERR_EN macro.
package fifo_pkg;

    // Error vector layout: {overflow, underflow}
    localparam int ERR_W   = 2;
    localparam int ERR_OVF = 1;
    localparam int ERR_UNF = 0;

    // Reset values of the single-bit outputs
    localparam logic RST_EMPTY     = 1'b1;
    localparam logic RST_FULL      = 1'b0;
    localparam logic RST_VALID     = 1'b0;
    localparam logic [ERR_W-1:0] RST_ERR = '0;

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one registered read port.
// Storage is not reset; only the read register returns to zero.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Write port; a same-address read on this edge still sees the old word
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register holds its value when no read is issued
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO for transaction-layer virtual-channel buffers.
// Pointer, occupancy, flag and optional sticky error logic (macro FIFO_ERR_EN).
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   umbral_superior,
    input  logic [ADDR_WIDTH:0]   umbral_inferior,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
`ifdef FIFO_ERR_EN
    output logic [ERR_W-1:0]      error,
`endif
    output logic [ADDR_WIDTH:0]   count
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_valid;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    // Flags decode only the registered count, so push/pop never reach them
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_FULL);
    // A simultaneous pop frees the slot, so push on full is still accepted
    assign w_pop_ok  = pop & ~w_empty;
    assign w_push_ok = push & (~w_full | w_pop_ok);

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
            else if (w_pop_ok && !w_push_ok) r_count <= r_count - 1'b1;
        end
    end

    // Read-valid marks a word popped on the previous edge
    always_ff @(posedge clk) begin
        if (reset) r_valid <= RST_VALID;
        else       r_valid <= w_pop_ok;
    end

`ifdef FIFO_ERR_EN
    logic [ERR_W-1:0] r_error;

    // Sticky error bits, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= RST_ERR;
        end else begin
            if (push && !w_push_ok) r_error[ERR_OVF] <= 1'b1;
            if (pop && w_empty)     r_error[ERR_UNF] <= 1'b1;
        end
    end

    assign error = r_error;
`endif

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_pop_ok),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (data_out)
    );

    assign valid_out    = r_valid;
    assign empty        = w_empty;
    assign full         = w_full;
    assign count        = r_count;
    // Thresholds are quasi-static and feed the flags combinationally
    assign almost_empty = (r_count <= umbral_inferior);
    assign almost_full  = (umbral_superior != '0) && (r_count >= umbral_superior);

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (default 10-bit x 8 configuration).
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic [9:0] data_in;
    logic [3:0] umbral_superior;
    logic [3:0] umbral_inferior;
    logic [9:0] data_out;
    logic       valid_out;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [3:0] count;
`ifdef FIFO_ERR_EN
    logic [1:0] error;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fifo_param #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .push            (push),
        .pop             (pop),
        .data_in         (data_in),
        .umbral_superior (umbral_superior),
        .umbral_inferior (umbral_inferior),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .empty           (empty),
        .full            (full),
        .almost_empty    (almost_empty),
        .almost_full     (almost_full),
`ifdef FIFO_ERR_EN
        .error           (error),
`endif
        .count           (count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: drive inputs, take the edge, settle 1 time unit past it
    task automatic step(input logic r, input logic pu, input logic po, input logic [9:0] d);
        reset = r; push = pu; pop = po; data_in = d;
        @(posedge clk);
        #1;
        reset = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
        umbral_superior = 4'd6; umbral_inferior = 4'd2;

        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_empty", 16'(empty), 16'd1);
        chk("rst_full", 16'(full), 16'd0);
        chk("rst_count", 16'(count), 16'd0);
        chk("rst_ae", 16'(almost_empty), 16'd1);
        chk("rst_af", 16'(almost_full), 16'd0);
        chk("rst_valid", 16'(valid_out), 16'd0);
        chk("rst_dout", 16'(data_out), 16'd0);
`ifdef FIFO_ERR_EN
        chk("rst_err", 16'(error), 16'd0);
`endif

        // Fill with 0x001..0x008
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 0, 10'(i));
            chk("fill_count", 16'(count), 16'(i));
            chk("fill_af", 16'(almost_full), 16'(i >= 6));
            chk("fill_ae", 16'(almost_empty), 16'(i <= 2));
            chk("fill_full", 16'(full), 16'(i == 8));
            chk("fill_empty", 16'(empty), 16'd0);
        end

        // Overflow: dropped word
        step(0, 1, 0, 10'h3FF);
        chk("ovf_count", 16'(count), 16'd8);
        chk("ovf_full", 16'(full), 16'd1);
`ifdef FIFO_ERR_EN
        chk("ovf_err", 16'(error), 16'b10);
`endif

        // Drain in order
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 1, 0);
            chk("drain_dout", 16'(data_out), 16'(k));
            chk("drain_valid", 16'(valid_out), 16'd1);
            chk("drain_count", 16'(count), 16'(8 - k));
            chk("drain_ae", 16'(almost_empty), 16'((8 - k) <= 2));
        end
        chk("drain_empty", 16'(empty), 16'd1);
        step(0, 0, 0, 0);
        chk("idle_valid", 16'(valid_out), 16'd0);
        chk("idle_hold", 16'(data_out), 16'h008);

        // Underflow after a fresh reset
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("unf_valid", 16'(valid_out), 16'd0);
        chk("unf_count", 16'(count), 16'd0);
`ifdef FIFO_ERR_EN
        chk("unf_err", 16'(error), 16'b01);
`endif

        // Full, push+pop together, then drain across the wrap
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 10'h011 + 10'(i));
        chk("wrap_full", 16'(full), 16'd1);
        step(0, 1, 1, 10'h155);
        chk("both_full_dout", 16'(data_out), 16'h011);
        chk("both_full_valid", 16'(valid_out), 16'd1);
        chk("both_full_count", 16'(count), 16'd8);
        for (int k = 0; k < 7; k++) begin
            step(0, 0, 1, 0);
            chk("wrap_dout", 16'(data_out), 16'h012 + 16'(k));
        end
        step(0, 0, 1, 0);
        chk("wrap_last", 16'(data_out), 16'h155);
        chk("wrap_empty", 16'(empty), 16'd1);

        // Empty, push+pop together: only push accepted
        step(0, 1, 1, 10'h2AA);
        chk("both_empty_count", 16'(count), 16'd1);
        chk("both_empty_valid", 16'(valid_out), 16'd0);
`ifdef FIFO_ERR_EN
        chk("both_empty_unf", 16'(error[0]), 16'd1);
`endif
        step(0, 0, 1, 0);
        chk("both_empty_dout", 16'(data_out), 16'h2AA);
        chk("both_empty_v2", 16'(valid_out), 16'd1);
        chk("both_empty_c2", 16'(count), 16'd0);

        // Reset mid-operation with a push in the same cycle
        for (int i = 0; i < 5; i++) step(0, 1, 0, 10'h0A0 + 10'(i));
        chk("mid_count5", 16'(count), 16'd5);
        step(1, 1, 0, 10'h0FF);
        chk("mid_count", 16'(count), 16'd0);
        chk("mid_empty", 16'(empty), 16'd1);
        chk("mid_dout", 16'(data_out), 16'd0);
`ifdef FIFO_ERR_EN
        chk("mid_err", 16'(error), 16'd0);
`endif
        step(0, 0, 1, 0);
        chk("mid_discard", 16'(valid_out), 16'd0);

        // Threshold 0 disables almost_full
        umbral_superior = 4'd0;
        #1;
        chk("af_disabled", 16'(almost_full), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
